// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared definitions for the MEM/WB pipeline register slice.
//   - Load-type encodings carried on mem_ld_type.
//   - Bus widths and common constants (RstEnable, WriteEnable, ZeroWord).
//   - wb_t: the register bundle latched at the MEM/WB boundary.
//   - is_load(): true for the five real load encodings (reserved = none).
package mem_wb_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic              RstEnable    = 1'b1;
  localparam logic              WriteEnable  = 1'b1;
  localparam logic              WriteDisable = 1'b0;
  localparam logic [RegBus-1:0] ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] RegZero  = '0;

  localparam int LdTypeW = 3;
  localparam logic [LdTypeW-1:0] LdNone = 3'b000;
  localparam logic [LdTypeW-1:0] LdLb   = 3'b001;
  localparam logic [LdTypeW-1:0] LdLbu  = 3'b010;
  localparam logic [LdTypeW-1:0] LdLh   = 3'b011;
  localparam logic [LdTypeW-1:0] LdLhu  = 3'b100;
  localparam logic [LdTypeW-1:0] LdLw   = 3'b101;

  typedef struct packed {
    logic                  wreg;
    logic [RegAddrBus-1:0] wd;
    logic [RegBus-1:0]     wdata;
    logic                  whilo;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  adel;
  } wb_t;

  function automatic logic is_load(input logic [LdTypeW-1:0] ld);
    return (ld == LdLb) || (ld == LdLbu) || (ld == LdLh) ||
           (ld == LdLhu) || (ld == LdLw);
  endfunction

endpackage

// File: rtl/mem_wb_load_align.sv
// load_align: combinational load-data extraction.
//   ld_type : load encoding (reserved codes behave as none)
//   addr_lo : low two address bits of the load
//   rdata   : raw 32-bit memory word
//   data    : byte/half/word selected and sign/zero extended (0 if misaligned)
//   adel    : misaligned halfword/word load
// BIG_ENDIAN=1 places byte address 0 in rdata[31:24], otherwise in rdata[7:0].
module load_align
  import mem_wb_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic [LdTypeW-1:0] ld_type,
  input  logic [1:0]         addr_lo,
  input  logic [RegBus-1:0]  rdata,
  output logic [RegBus-1:0]  data,
  output logic               adel
);

  logic [1:0]  byte_idx;
  logic        half_idx;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    // Map the address to a physical lane index; big-endian reverses lanes.
    byte_idx = (BIG_ENDIAN != 0) ? (2'd3 - addr_lo) : addr_lo;
    half_idx = (BIG_ENDIAN != 0) ? ~addr_lo[1] : addr_lo[1];
    byte_sel = rdata[{byte_idx, 3'b000} +: 8];
    half_sel = rdata[{half_idx, 4'b0000} +: 16];
    data     = ZeroWord;
    adel     = 1'b0;
    case (ld_type)
      LdLb:  data = {{24{byte_sel[7]}}, byte_sel};
      LdLbu: data = {24'h0, byte_sel};
      LdLh:  if (addr_lo[0]) adel = 1'b1;
             else data = {{16{half_sel[15]}}, half_sel};
      LdLhu: if (addr_lo[0]) adel = 1'b1;
             else data = {16'h0, half_sel};
      LdLw:  if (addr_lo != 2'b00) adel = 1'b1;
             else data = rdata;
      default: data = ZeroWord;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline register with load alignment and retire counter.
//   clk, rst                : clock, synchronous active-high reset
//   mem_wreg/wd/wdata       : MEM-stage register-file write request
//   mem_ld_type/addr_lo/rdata : load descriptor and raw memory word
//   mem_whilo/hi/lo         : MEM-stage HI/LO write request
//   stall_mem, stall_wb     : stall requests; flush: exception flush
//   wb_*                    : registered WB-stage outputs (1-cycle latency)
//   wb_adel                 : misaligned-load flag for the WB instruction
//   wb_retire_cnt           : committed register-file writes (wraps)
// Edge priority: rst > flush > bubble (stall_mem & !stall_wb) > hold > capture.
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_wreg,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic [RegBus-1:0]     mem_wdata,
  input  logic [LdTypeW-1:0]    mem_ld_type,
  input  logic [1:0]            mem_addr_lo,
  input  logic [RegBus-1:0]     mem_rdata,
  input  logic                  mem_whilo,
  input  logic [RegBus-1:0]     mem_hi,
  input  logic [RegBus-1:0]     mem_lo,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  output logic                  wb_wreg,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic [RegBus-1:0]     wb_wdata,
  output logic                  wb_whilo,
  output logic [RegBus-1:0]     wb_hi,
  output logic [RegBus-1:0]     wb_lo,
  output logic                  wb_adel,
  output logic [RegBus-1:0]     wb_retire_cnt
);

  wb_t               wb_d, wb_q;
  logic [RegBus-1:0] retire_cnt_d, retire_cnt_q;
  logic [RegBus-1:0] la_data;
  logic              la_adel;

  load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
    .ld_type (mem_ld_type),
    .addr_lo (mem_addr_lo),
    .rdata   (mem_rdata),
    .data    (la_data),
    .adel    (la_adel)
  );

  always_comb begin
    wb_d         = wb_q;
    retire_cnt_d = retire_cnt_q;
    if (flush || (stall_mem && !stall_wb)) begin
      wb_d = '0;
    end else if (stall_mem) begin
      wb_d = wb_q;
    end else begin
      wb_d.adel  = la_adel;
      // Misaligned loads and writes to $0 never reach the register file.
      wb_d.wreg  = (mem_wreg == WriteEnable) && (mem_wd != RegZero) && !la_adel;
      wb_d.wd    = mem_wd;
      wb_d.wdata = la_adel            ? ZeroWord :
                   is_load(mem_ld_type) ? la_data : mem_wdata;
      wb_d.whilo = mem_whilo;
      wb_d.hi    = mem_hi;
      wb_d.lo    = mem_lo;
      if (wb_d.wreg) retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      wb_q         <= '0;
      retire_cnt_q <= ZeroWord;
    end else begin
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign wb_wreg       = wb_q.wreg;
  assign wb_wd         = wb_q.wd;
  assign wb_wdata      = wb_q.wdata;
  assign wb_whilo      = wb_q.whilo;
  assign wb_hi         = wb_q.hi;
  assign wb_lo         = wb_q.lo;
  assign wb_adel       = wb_q.adel;
  assign wb_retire_cnt = retire_cnt_q;

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The block SHALL have exactly one parameter: BIG_ENDIAN, default 1, which selects byte-lane order for load extraction (1 means byte address 0 is in bits 31:24; 0 means it is in bits 7:0).
REQ-002 clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 mem_wreg  in  1  MEM-stage register-write enable.
REQ-005 mem_wd  in  5  MEM-stage destination register address.
REQ-006 mem_wdata  in  32  MEM-stage result for non-load instructions.
REQ-007 mem_ld_type  in  3  load type: 000 none, 001 LB, 010 LBU, 011 LH, 100 LHU, 101 LW; 110 and 111 are reserved and treated as none.
REQ-008 mem_addr_lo  in  2  low bits of the load address.
REQ-009 mem_rdata  in  32  raw data-memory read word.
REQ-010 mem_whilo, mem_hi, mem_lo  in  1/32/32  HI/LO write enable and data.
REQ-011 stall_mem, stall_wb  in  1/1  pipeline stall requests from the controller.
REQ-012 flush  in  1  exception flush request.
REQ-013 wb_wreg, wb_wd, wb_wdata  out  1/5/32  register-file write port (drives we/waddr/wdata).
REQ-014 wb_whilo, wb_hi, wb_lo  out  1/32/32  HI/LO write port.
REQ-015 wb_adel  out  1  misaligned-load flag for the instruction now in WB.
REQ-016 wb_retire_cnt  out  32  count of register-file writes committed.

Function
REQ-017 All outputs SHALL be registered; the latency from MEM inputs to WB outputs SHALL be exactly one cycle.
REQ-018 Update priority each edge SHALL be: rst, then flush, then (stall_mem=1 and stall_wb=0), then (stall_mem=1 and stall_wb=1), then normal capture.
REQ-019 On flush, the block SHALL load a bubble: all data outputs 0 and all enables 0.
REQ-020 When stall_mem=1 and stall_wb=0, the block SHALL load a bubble.
REQ-021 When stall_mem=1 and stall_wb=1, the block SHALL hold every output register unchanged.
REQ-022 When stall_mem=0, normal capture SHALL apply and stall_wb SHALL be ignored.
REQ-023 On normal capture with ld_type none, wb_wdata SHALL equal mem_wdata.
REQ-024 LB/LBU SHALL select the byte at mem_addr_lo under BIG_ENDIAN and then sign-extend or zero-extend it to 32 bits.
REQ-025 LH/LHU SHALL select the halfword at mem_addr_lo[1] under BIG_ENDIAN and then sign-extend or zero-extend it to 32 bits.
REQ-026 LW SHALL pass mem_rdata unchanged.
REQ-027 An LH/LHU with mem_addr_lo[0]=1, or an LW with mem_addr_lo!=00, SHALL capture wb_adel=1, wb_wreg=0 and wb_wdata=0.
REQ-028 A capture with mem_wd=0 SHALL force wb_wreg=0, so register $0 is never written.
REQ-029 HI/LO fields SHALL be captured unchanged on normal capture; they SHALL be zeroed with the enable on bubbles and held on hold.
REQ-030 wb_retire_cnt SHALL increment by 1 on every edge at which the newly captured wb_wreg is 1.
REQ-031 wb_retire_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-032 wb_retire_cnt SHALL NOT change on hold, bubble or flush.
REQ-033 wb_adel SHALL be a one-cycle flag that clears on the next capture or bubble; it SHALL persist while held.

Reset
REQ-034 While rst=1 at a rising edge, every output, including wb_retire_cnt, SHALL become 0 regardless of flush or stall.
REQ-035 Reset asserted mid-stall SHALL discard the held instruction.
REQ-036 The first capture after reset deasserts SHALL occur on the first edge with rst=0.

Structure
REQ-037 The load-type encodings, RstEnable, WriteEnable, ZeroWord, RegAddrBus and RegBus SHALL reside in the shared defines file; no local magic numbers SHALL be used.
REQ-038 Load extraction SHALL be a purely combinational sub-module named load_align (inputs ld_type, addr_lo, rdata; outputs data, adel), parameterised by BIG_ENDIAN.

Verification
REQ-039 The bench SHALL drive mem_ld_type=LB, addr_lo=01, rdata=0x12F45678, BIG_ENDIAN=1, with wreg=1 and wd=3, and SHALL check that the next cycle gives wb_wdata=0xFFFFFFF4, wb_wreg=1, wb_wd=3 and wb_retire_cnt=1.
REQ-040 The bench SHALL drive LHU with addr_lo=10 and rdata=0x1234ABCD, and SHALL check wb_wdata=0x0000ABCD; it SHALL then drive LW with addr_lo=01 and check wb_adel=1 and wb_wreg=0, with the counter unchanged.
REQ-041 The bench SHALL capture wd=5, wdata=0xDEADBEEF, then hold stall_mem=1 and stall_wb=1 for 3 cycles, and SHALL check that the outputs stay 0xDEADBEEF/5/1 throughout; it SHALL then set stall_wb=0 and check that a bubble appears (wb_wreg=0).
REQ-042 The bench SHALL assert flush and stall_mem=1 together with valid MEM inputs, and SHALL check that the result is a bubble with the counter unchanged.
REQ-043 The bench SHALL preload wb_retire_cnt=0xFFFFFFFF by running through the wrap path (forced start), then perform one write, and SHALL check a count of 0; it SHALL also check that a write with wd=0 yields wb_wreg=0 and no increment.
REQ-044 The bench SHALL assert rst for one cycle during a 2-cycle hold, and SHALL check that all outputs are 0 on the following cycle.
